pipe_control: RTL and testbench
===============================

Name: pipe_control

Overview:
- Pipelined successor to the single-cycle control unit for the RV32I core.
- Decodes the instruction word in the D stage and carries the control bundle through the D→E, E→M and M→W pipeline registers.
- Supports stage flush/stall, the full RV32I branch set, and LUI/AUIPC/JALR.
- Sits beside the datapath and hazard unit. It exports per-stage control fields and resolves the PC source in E.

Parameters:
- ALU_CTRL_W, 4, width of ALU operation select (4 bits cover ADD..PASSB encodings).
- IMM_SRC_W, 3, width of immediate-format select (I/S/B/J/U).
- RESULT_SRC_W, 2, width of writeback mux select.

Ports:
- i_clk  input  1  core clock
- i_rst  input  1  reset; synchronous, active-high
- i_instr_d  input  32  instruction in D stage
- i_stall_d  input  1  hold D→E register (E/M/W keep advancing; E receives bubble)
- i_flush_e  input  1  replace E contents with bubble
- i_zero_e, i_lt_e, i_ltu_e  input  1 each  ALU flags for E-stage compare
- o_imm_src_d  output  IMM_SRC_W  extender select, combinational from i_instr_d
- o_illegal_d  output  1  unrecognised opcode/funct in D
- o_alu_control_e  output  ALU_CTRL_W  ALU op
- o_alu_src_a_e  output  1  0 = rs1, 1 = PC (AUIPC)
- o_alu_src_b_e  output  1  0 = rs2, 1 = imm
- o_pc_src_e  output  1  redirect fetch this cycle
- o_pc_tgt_src_e  output  1  0 = PC+imm, 1 = ALU result (JALR)
- o_result_src_e0  output  1  E-stage result_src==MEM, for load-use detection
- o_reg_write_m, o_mem_write_m  output  1 each
- o_result_src_m  output  RESULT_SRC_W
- o_reg_write_w  output  1
- o_result_src_w  output  RESULT_SRC_W

Behaviour:
- Reset: all E/M/W stage registers are cleared to bubble on the next i_clk edge while i_rst=1. All registered outputs read 0. A reset mid-instruction discards all in-flight control.
- Bubble: reg_write=0, mem_write=0, branch=0, jump=0, alu_control=ADD. No architectural effect.
- Latency: decode is combinational in D. Fields appear at E one cycle later, at M two cycles later, and at W three cycles later.

Decode (D stage):
- lw: reg_write=1, alu_src_b=1, result=MEM(01), imm=I.
- sw: mem_write=1, alu_src_b=1, imm=S.
- R-type: funct3/funct7[30] select ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- I-ALU: as R-type, except funct7[30] selects SUB never and SRA only for funct3=101.
- branch (1100011): branch=1, ALU=SUB, imm=B. funct3 is carried to E.
- jal: jump=1, result=PC+4(10), imm=J.
- jalr: jump=1, pc_tgt_src=1, alu_src_b=1, imm=I, result=PC+4.
- lui: ALU=PASSB, alu_src_b=1, imm=U.
- auipc: alu_src_a=1, alu_src_b=1, ALU=ADD, imm=U.
- Any other opcode, or branch funct3 010/011: o_illegal_d=1. The bundle forwarded to E is a bubble.

ALU encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLTU 6, SLL 7, SRL 8, SRA 9, PASSB 10.

E stage, o_pc_src_e = jump_e | (branch_e & taken), where taken is selected by funct3_e:
- BEQ: zero
- BNE: !zero
- BLT: lt
- BGE: !lt
- BLTU: ltu
- BGEU: !ltu

Stall/flush rules:
- i_flush_e takes priority over i_stall_d: E gets a bubble.
- i_stall_d=1 with i_flush_e=0: E also gets a bubble, because D holds while E must not duplicate the instruction.
- M and W are never stalled. They always advance from E and M respectively.

Decomposition:
- Package riscv_pkg holds:
  - opcode localparams;
  - enums alu_ctrl_e, imm_src_e, result_src_e;
  - struct ctrl_t {reg_write, result_src, mem_write, jump, branch, funct3, alu_control, alu_src_a, alu_src_b, pc_tgt_src};
  - the constant CTRL_BUBBLE.
- Sub-module pipe_decoder: combinational instr→ctrl_t plus illegal flag.
- pipe_control instantiates pipe_decoder and implements the three stage registers plus branch resolution.

Test Plan:
- 0x002081B3 (add) then idle → o_alu_control_e=0 at cycle+1; o_reg_write_m=1 at +2; o_reg_write_w=1, o_result_src_w=00 at +3.
- 0x402081B3 (sub) → o_alu_control_e=1. Follow with 0x0040A283 (lw) → o_result_src_e0=1, o_alu_src_b_e=1, o_imm_src_d=000.
- 0x00208463 (beq) with i_zero_e=1 → o_pc_src_e=1; with i_zero_e=0 → 0. 0x00209463 (bne) with i_zero_e=0 → o_pc_src_e=1.
- 0x008000EF (jal) → o_pc_src_e=1 regardless of flags, o_pc_tgt_src_e=0, o_result_src_w=10 at +3. 0x123452B7 (lui) → o_alu_control_e=10, o_imm_src_d=100.
- sw 0x0050A423 in D with i_flush_e=1 → o_mem_write_m=0 two cycles later. The same with i_stall_d=1 → also bubble.
- Pipeline full of lw/add/sw, assert i_rst for one cycle → all E/M/W outputs 0 on the next edge. Opcode 0x7F in D → o_illegal_d=1 and a bubble at E.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I control types: opcodes, ALU/immediate/result select encodings
// and the control bundle carried down the pipeline.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  funct3;
    alu_ctrl_e   alu_control;
    logic        alu_src_a;
    logic        alu_src_b;
    logic        pc_tgt_src;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    reg_write:   1'b0,
    result_src:  RES_ALU,
    mem_write:   1'b0,
    jump:        1'b0,
    branch:      1'b0,
    funct3:      3'b000,
    alu_control: ALU_ADD,
    alu_src_a:   1'b0,
    alu_src_b:   1'b0,
    pc_tgt_src:  1'b0
  };

  // alt selects SUB for funct3=000 and SRA for funct3=101; the caller decides
  // whether instr[30] is allowed to mean that for its format.
  function automatic alu_ctrl_e alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/pipe_decoder.sv
// D-stage decoder: instruction word to control bundle, immediate select and
// illegal flag; purely combinational, illegal encodings yield a bubble.
module pipe_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output imm_src_e    imm_src,
  output logic        illegal
);

  logic [2:0] funct3;
  logic       alt;
  logic       unused_fields;

  assign funct3        = instr[14:12];
  assign alt           = instr[30];
  assign unused_fields = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    imm_src = IMM_I;
    illegal = 1'b0;
    case (instr[6:0])
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src_b  = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_src        = IMM_S;
      end
      OP_R: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = alu_op(funct3, alt);
      end
      OP_I: begin
        // Immediate forms have no SUB; bit 30 only distinguishes SRAI.
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_b   = 1'b1;
        ctrl.alu_control = alu_op(funct3, alt && (funct3 == 3'b101));
      end
      OP_BRANCH: begin
        imm_src = IMM_B;
        if (funct3[2:1] == 2'b01) begin
          illegal = 1'b1;
        end else begin
          ctrl.branch      = 1'b1;
          ctrl.alu_control = ALU_SUB;
          ctrl.funct3      = funct3;
        end
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.result_src = RES_PC4;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.pc_tgt_src = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_control = ALU_PASSB;
        ctrl.alu_src_b   = 1'b1;
        imm_src          = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        imm_src        = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipe_control.sv
// Pipelined RV32I control: D decode, D->E/E->M/M->W control registers, E-stage
// branch resolution. Stall or flush bubbles E; M and W always advance.
module pipe_control
  import riscv_pkg::*;
#(
  parameter int ALU_CTRL_W   = 4,
  parameter int IMM_SRC_W    = 3,
  parameter int RESULT_SRC_W = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [31:0]             i_instr_d,
  input  logic                    i_stall_d,
  input  logic                    i_flush_e,
  input  logic                    i_zero_e,
  input  logic                    i_lt_e,
  input  logic                    i_ltu_e,
  output logic [IMM_SRC_W-1:0]    o_imm_src_d,
  output logic                    o_illegal_d,
  output logic [ALU_CTRL_W-1:0]   o_alu_control_e,
  output logic                    o_alu_src_a_e,
  output logic                    o_alu_src_b_e,
  output logic                    o_pc_src_e,
  output logic                    o_pc_tgt_src_e,
  output logic                    o_result_src_e0,
  output logic                    o_reg_write_m,
  output logic                    o_mem_write_m,
  output logic [RESULT_SRC_W-1:0] o_result_src_m,
  output logic                    o_reg_write_w,
  output logic [RESULT_SRC_W-1:0] o_result_src_w
);

  ctrl_t       ctrl_d;
  ctrl_t       ctrl_e;
  imm_src_e    imm_src_d;
  logic        reg_write_m;
  logic        mem_write_m;
  result_src_e result_src_m;
  logic        reg_write_w;
  result_src_e result_src_w;
  logic        taken;

  pipe_decoder u_decoder (
    .instr   (i_instr_d),
    .ctrl    (ctrl_d),
    .imm_src (imm_src_d),
    .illegal (o_illegal_d)
  );

  // A stalled D stage keeps its instruction, so E must take a bubble rather
  // than a second copy of it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_e       <= CTRL_BUBBLE;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= RES_ALU;
      reg_write_w  <= 1'b0;
      result_src_w <= RES_ALU;
    end else begin
      ctrl_e       <= (i_flush_e || i_stall_d) ? CTRL_BUBBLE : ctrl_d;
      reg_write_m  <= ctrl_e.reg_write;
      mem_write_m  <= ctrl_e.mem_write;
      result_src_m <= ctrl_e.result_src;
      reg_write_w  <= reg_write_m;
      result_src_w <= result_src_m;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (ctrl_e.funct3)
      3'b000:  taken = i_zero_e;
      3'b001:  taken = !i_zero_e;
      3'b100:  taken = i_lt_e;
      3'b101:  taken = !i_lt_e;
      3'b110:  taken = i_ltu_e;
      3'b111:  taken = !i_ltu_e;
      default: taken = 1'b0;
    endcase
  end

  assign o_imm_src_d     = IMM_SRC_W'(imm_src_d);
  assign o_alu_control_e = ALU_CTRL_W'(ctrl_e.alu_control);
  assign o_alu_src_a_e   = ctrl_e.alu_src_a;
  assign o_alu_src_b_e   = ctrl_e.alu_src_b;
  assign o_pc_src_e      = ctrl_e.jump | (ctrl_e.branch & taken);
  assign o_pc_tgt_src_e  = ctrl_e.pc_tgt_src;
  assign o_result_src_e0 = (ctrl_e.result_src == RES_MEM);
  assign o_reg_write_m   = reg_write_m;
  assign o_mem_write_m   = mem_write_m;
  assign o_result_src_m  = RESULT_SRC_W'(result_src_m);
  assign o_reg_write_w   = reg_write_w;
  assign o_result_src_w  = RESULT_SRC_W'(result_src_w);

endmodule

// File: tb/tb_pipe_control.sv
// Bench for pipe_control: directed scenarios plus randomized instruction/stall/
// flush/reset traffic against a behavioural model of the control pipeline.
module tb_pipe_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_d;
  logic        stall_d, flush_e, zero_e, lt_e, ltu_e;
  logic [2:0]  imm_src_d;
  logic        illegal_d;
  logic [3:0]  alu_control_e;
  logic        alu_src_a_e, alu_src_b_e, pc_src_e, pc_tgt_src_e, result_src_e0;
  logic        reg_write_m, mem_write_m, reg_write_w;
  logic [1:0]  result_src_m, result_src_w;

  always #5 clk = ~clk;

  pipe_control dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_instr_d       (instr_d),
    .i_stall_d       (stall_d),
    .i_flush_e       (flush_e),
    .i_zero_e        (zero_e),
    .i_lt_e          (lt_e),
    .i_ltu_e         (ltu_e),
    .o_imm_src_d     (imm_src_d),
    .o_illegal_d     (illegal_d),
    .o_alu_control_e (alu_control_e),
    .o_alu_src_a_e   (alu_src_a_e),
    .o_alu_src_b_e   (alu_src_b_e),
    .o_pc_src_e      (pc_src_e),
    .o_pc_tgt_src_e  (pc_tgt_src_e),
    .o_result_src_e0 (result_src_e0),
    .o_reg_write_m   (reg_write_m),
    .o_mem_write_m   (mem_write_m),
    .o_result_src_m  (result_src_m),
    .o_reg_write_w   (reg_write_w),
    .o_result_src_w  (result_src_w)
  );

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       jump;
    logic       branch;
    logic [2:0] f3;
    logic [3:0] alu;
    logic       sa;
    logic       sb;
    logic       tgt;
    logic [2:0] imm;
    logic       ill;
  } exp_t;

  // ALU op named by funct3 alone: ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [3:0] ALU_BY_F3 [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
  localparam logic [6:0] OPS [10] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63,
                                      7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0040A283;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_SW   = 32'h0050A423;
  localparam logic [31:0] I_IDLE = 32'h00000000;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t me, mm, mw;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t model_decode(input logic [31:0] ins);
    exp_t       x;
    logic [2:0] f3;
    x  = '0;
    f3 = ins[14:12];
    case (ins[6:0])
      7'h03: begin x.rw = 1; x.rs = 2'd1; x.sb = 1; x.imm = 3'd0; end
      7'h23: begin x.mw = 1; x.sb = 1; x.imm = 3'd1; end
      7'h33: begin
        x.rw  = 1;
        x.alu = ALU_BY_F3[f3];
        if (ins[30] && f3 == 3'd0) x.alu = 4'd1;
        if (ins[30] && f3 == 3'd5) x.alu = 4'd9;
      end
      7'h13: begin
        x.rw  = 1;
        x.sb  = 1;
        x.alu = ALU_BY_F3[f3];
        if (ins[30] && f3 == 3'd5) x.alu = 4'd9;
      end
      7'h63: begin
        x.imm = 3'd2;
        if (f3 == 3'd2 || f3 == 3'd3) x.ill = 1;
        else begin x.branch = 1; x.alu = 4'd1; x.f3 = f3; end
      end
      7'h6F: begin x.rw = 1; x.jump = 1; x.rs = 2'd2; x.imm = 3'd3; end
      7'h67: begin x.rw = 1; x.jump = 1; x.tgt = 1; x.sb = 1; x.rs = 2'd2; end
      7'h37: begin x.rw = 1; x.alu = 4'd10; x.sb = 1; x.imm = 3'd4; end
      7'h17: begin x.rw = 1; x.sa = 1; x.sb = 1; x.imm = 3'd4; end
      default: x.ill = 1;
    endcase
    return x;
  endfunction

  // Branch outcome from the operands themselves, by branch mnemonic.
  function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cycle(input logic [31:0] ins, input logic s, input logic f, input logic r,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t d;
    instr_d = ins;
    stall_d = s;
    flush_e = f;
    rst     = r;
    zero_e  = (a == b);
    lt_e    = ($signed(a) < $signed(b));
    ltu_e   = (a < b);
    d = model_decode(ins);
    @(negedge clk);
    check("imm_src_d", {29'd0, imm_src_d}, {29'd0, d.imm});
    check("illegal_d", {31'd0, illegal_d}, {31'd0, d.ill});
    check("alu_control_e", {28'd0, alu_control_e}, {28'd0, me.alu});
    check("alu_src_a_e", {31'd0, alu_src_a_e}, {31'd0, me.sa});
    check("alu_src_b_e", {31'd0, alu_src_b_e}, {31'd0, me.sb});
    check("pc_tgt_src_e", {31'd0, pc_tgt_src_e}, {31'd0, me.tgt});
    check("result_src_e0", {31'd0, result_src_e0}, {31'd0, (me.rs == 2'd1)});
    check("pc_src_e", {31'd0, pc_src_e},
          {31'd0, me.jump | (me.branch & model_taken(me.f3, a, b))});
    check("reg_write_m", {31'd0, reg_write_m}, {31'd0, mm.rw});
    check("mem_write_m", {31'd0, mem_write_m}, {31'd0, mm.mw});
    check("result_src_m", {30'd0, result_src_m}, {30'd0, mm.rs});
    check("reg_write_w", {31'd0, reg_write_w}, {31'd0, mw.rw});
    check("result_src_w", {30'd0, result_src_w}, {30'd0, mw.rs});
    @(posedge clk);
    if (r) begin
      me = '0; mm = '0; mw = '0;
    end else begin
      mw = mm;
      mm = me;
      me = (s || f || d.ill) ? exp_t'('0) : d;
    end
    #1;
  endtask

  task automatic go(input logic [31:0] ins);
    cycle(ins, 1'b0, 1'b0, 1'b0, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] ins, a, b;
    logic [6:0]  op;
    int          k;

    instr_d = I_IDLE; stall_d = 0; flush_e = 0; zero_e = 0; lt_e = 0; ltu_e = 0; rst = 1;
    me = '0; mm = '0; mw = '0;
    repeat (2) @(posedge clk);
    #1;
    cycle(I_IDLE, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    check("rst_alu_e", {28'd0, alu_control_e}, 32'd0);
    check("rst_reg_write_w", {31'd0, reg_write_w}, 32'd0);

    // add flows E -> M -> W
    go(I_ADD);
    check("add_alu_e", {28'd0, alu_control_e}, 32'd0);
    go(I_IDLE);
    check("add_reg_write_m", {31'd0, reg_write_m}, 32'd1);
    go(I_IDLE);
    check("add_reg_write_w", {31'd0, reg_write_w}, 32'd1);
    check("add_result_src_w", {30'd0, result_src_w}, 32'd0);

    go(I_SUB);
    check("sub_alu_e", {28'd0, alu_control_e}, 32'd1);
    go(I_LW);
    check("lw_result_src_e0", {31'd0, result_src_e0}, 32'd1);
    check("lw_alu_src_b_e", {31'd0, alu_src_b_e}, 32'd1);
    check("lw_imm_src_d", {29'd0, imm_src_d}, 32'd0);

    go(I_BEQ);
    zero_e = 1; #1;
    check("beq_taken", {31'd0, pc_src_e}, 32'd1);
    zero_e = 0; #1;
    check("beq_not_taken", {31'd0, pc_src_e}, 32'd0);
    go(I_BNE);
    zero_e = 0; #1;
    check("bne_taken", {31'd0, pc_src_e}, 32'd1);

    go(I_JAL);
    zero_e = 0; lt_e = 1; ltu_e = 0; #1;
    check("jal_pc_src", {31'd0, pc_src_e}, 32'd1);
    check("jal_pc_tgt_src", {31'd0, pc_tgt_src_e}, 32'd0);
    go(I_IDLE);
    go(I_IDLE);
    check("jal_result_src_w", {30'd0, result_src_w}, 32'd2);

    go(I_LUI);
    check("lui_alu_e", {28'd0, alu_control_e}, 32'd10);
    check("lui_imm_src_d", {29'd0, imm_src_d}, 32'd4);

    go(I_SW);
    go(I_IDLE);
    check("sw_mem_write_m", {31'd0, mem_write_m}, 32'd1);
    cycle(I_SW, 1'b0, 1'b1, 1'b0, 32'd0, 32'd1);
    go(I_IDLE);
    check("sw_flush_mem_write_m", {31'd0, mem_write_m}, 32'd0);
    cycle(I_SW, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1);
    go(I_IDLE);
    check("sw_stall_mem_write_m", {31'd0, mem_write_m}, 32'd0);

    // reset with a full pipeline
    go(I_LW);
    go(I_ADD);
    go(I_SW);
    cycle(I_ADD, 1'b0, 1'b0, 1'b1, 32'd0, 32'd1);
    check("rst_reg_write_m", {31'd0, reg_write_m}, 32'd0);
    check("rst_mem_write_m", {31'd0, mem_write_m}, 32'd0);
    check("rst_result_src_m", {30'd0, result_src_m}, 32'd0);
    check("rst_reg_write_w2", {31'd0, reg_write_w}, 32'd0);
    check("rst_result_src_w", {30'd0, result_src_w}, 32'd0);
    check("rst_alu_src_b_e", {31'd0, alu_src_b_e}, 32'd0);

    go(I_LW);
    go(32'h0000007F);
    check("illegal_d", {31'd0, illegal_d}, 32'd1);
    check("illegal_bubble_src_b", {31'd0, alu_src_b_e}, 32'd0);
    check("illegal_bubble_e0", {31'd0, result_src_e0}, 32'd0);

    for (int n = 0; n < 600; n++) begin
      k   = $urandom_range(0, 10);
      op  = (k == 10) ? 7'($urandom) : OPS[k];
      ins = {$urandom, 7'd0} | {25'd0, op};
      ins[6:0] = op;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b[31] = ~a[31];
      cycle(ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 49) == 0), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
